// File: rtl/brdec_pipe.sv
// Branch predecoder for one fetch bundle: per-slot decode, first-branch select from the
// entry slot, BTB/RAS payload and instruction-valid mask behind a one-deep valid/ready register.
module brdec_pipe #(
    parameter int FETCH_W = 8,
    parameter int ADDR_W  = 64,
    localparam int SW     = $clog2(FETCH_W)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ADDR_W-1:0]     pc_i,
    input  logic [32*FETCH_W-1:0] inst_i,
    input  logic [ADDR_W-1:0]     ras_top_i,
    input  logic                  valid_override_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  br_exist_o,
    output logic                  btb_we_o,
    output logic [SW-1:0]         btb_br_pos_o,
    output logic [1:0]            btb_br_typ_o,
    output logic [ADDR_W-1:0]     btb_br_tar_o,
    output logic [1:0]            ras_ctrl_o,
    output logic [ADDR_W-1:0]     ras_data_o,
    output logic                  multi_br_o,
    output logic [FETCH_W-1:0]    inst_valid_o,
    output logic [31:0]           br_cnt_o
);

    logic [ADDR_W-1:0]  base;
    logic [SW-1:0]      entry;
    logic [FETCH_W-1:0] slot_br;
    logic [FETCH_W-1:0] in_range;
    logic [FETCH_W-1:0] cand;
    logic [1:0]         slot_typ [FETCH_W];
    logic [1:0]         slot_ras [FETCH_W];
    logic [ADDR_W-1:0]  slot_tar [FETCH_W];
    logic [ADDR_W-1:0]  slot_ret [FETCH_W];

    assign base  = {pc_i[ADDR_W-1:SW+2], {(SW+2){1'b0}}};
    assign entry = pc_i[SW+1:2];
    wire unused_pc = ^pc_i[1:0];

    generate
        for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_slot
            logic [31:0]       word;
            logic [5:0]        op;
            logic [ADDR_W-1:0] slot_pc;
            logic [ADDR_W-1:0] disp_sh;
            logic              br_l;
            logic [1:0]        typ_l;
            logic [1:0]        ras_l;

            assign word    = inst_i[32*gi +: 32];
            assign op      = word[31:26];
            assign slot_pc = base + ADDR_W'(4 * gi);
            assign disp_sh = ADDR_W'({{ADDR_W{word[20]}}, word[20:0], 2'b00});
            wire unused_word = ^word[25:21];

            always_comb begin
                br_l  = 1'b0;
                typ_l = 2'b00;
                ras_l = 2'b00;
                if (op == 6'h30) begin
                    br_l  = 1'b1;
                    typ_l = 2'b01;
                end else if (op == 6'h34) begin
                    br_l  = 1'b1;
                    typ_l = 2'b01;
                    ras_l = 2'b01;
                end else if (op > 6'h30) begin
                    br_l  = 1'b1;
                end else if (op == 6'h1A) begin
                    // Hint bits pick JMP/JSR/RET/JSR_COROUTINE; RAS action maps 1:1.
                    br_l  = 1'b1;
                    typ_l = word[15] ? 2'b11 : 2'b10;
                    ras_l = word[15:14];
                end
            end

            assign slot_br[gi]  = br_l;
            assign slot_typ[gi] = typ_l;
            assign slot_ras[gi] = ras_l;
            assign slot_ret[gi] = slot_pc + ADDR_W'(4);
            assign slot_tar[gi] = typ_l[1] ? (typ_l[0] ? ras_top_i : '0)
                                           : slot_pc + ADDR_W'(4) + disp_sh;
            assign in_range[gi] = (SW'(gi) >= entry);
            assign cand[gi]     = br_l & in_range[gi];
        end
    endgenerate

    logic               found;
    logic [SW-1:0]      sel;
    logic               multi;
    logic [FETCH_W-1:0] iv;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = FETCH_W - 1; k >= 0; k--) begin
            if (cand[k]) begin
                found = 1'b1;
                sel   = SW'(k);
            end
        end
        // Clearing the lowest set bit leaves something only if two or more candidates exist.
        multi = |(cand & (cand - FETCH_W'(1)));
        for (int k = 0; k < FETCH_W; k++) begin
            iv[k] = in_range[k] & (~found | (SW'(k) <= sel));
        end
    end

    logic                br_exist_next;
    logic [SW-1:0]       pos_next;
    logic [1:0]          typ_next;
    logic [ADDR_W-1:0]   tar_next;
    logic [1:0]          ras_ctrl_next;
    logic [ADDR_W-1:0]   ras_data_next;
    logic                multi_next;
    logic [FETCH_W-1:0]  inst_valid_next;

    always_comb begin
        br_exist_next   = 1'b0;
        pos_next        = '0;
        typ_next        = 2'b00;
        tar_next        = '0;
        ras_ctrl_next   = 2'b00;
        ras_data_next   = '0;
        multi_next      = 1'b0;
        inst_valid_next = '0;
        if (!valid_override_i) begin
            multi_next      = multi;
            inst_valid_next = iv;
            if (found) begin
                br_exist_next = 1'b1;
                pos_next      = sel;
                typ_next      = slot_typ[sel];
                tar_next      = slot_tar[sel];
                ras_ctrl_next = slot_ras[sel];
                ras_data_next = slot_ret[sel];
            end
        end
    end

    logic                valid_reg;
    logic                br_exist_reg;
    logic [SW-1:0]       pos_reg;
    logic [1:0]          typ_reg;
    logic [ADDR_W-1:0]   tar_reg;
    logic [1:0]          ras_ctrl_reg;
    logic [ADDR_W-1:0]   ras_data_reg;
    logic                multi_reg;
    logic [FETCH_W-1:0]  inst_valid_reg;
    logic [31:0]         cnt_reg;
    logic                accept;

    assign in_ready_o = ~valid_reg | out_ready_i;
    assign accept     = in_valid_i & in_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_reg      <= 1'b0;
            br_exist_reg   <= 1'b0;
            pos_reg        <= '0;
            typ_reg        <= 2'b00;
            tar_reg        <= '0;
            ras_ctrl_reg   <= 2'b00;
            ras_data_reg   <= '0;
            multi_reg      <= 1'b0;
            inst_valid_reg <= '0;
            cnt_reg        <= '0;
        end else begin
            // Output handshakes count even when a flush lands in the same cycle.
            if (valid_reg && out_ready_i && br_exist_reg)
                cnt_reg <= cnt_reg + 32'd1;
            if (flush_i) begin
                valid_reg <= 1'b0;
            end else if (accept) begin
                valid_reg      <= 1'b1;
                br_exist_reg   <= br_exist_next;
                pos_reg        <= pos_next;
                typ_reg        <= typ_next;
                tar_reg        <= tar_next;
                ras_ctrl_reg   <= ras_ctrl_next;
                ras_data_reg   <= ras_data_next;
                multi_reg      <= multi_next;
                inst_valid_reg <= inst_valid_next;
            end else if (out_ready_i) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid_o  = valid_reg;
    assign br_exist_o   = br_exist_reg;
    assign btb_we_o     = br_exist_reg;
    assign btb_br_pos_o = pos_reg;
    assign btb_br_typ_o = typ_reg;
    assign btb_br_tar_o = tar_reg;
    assign ras_ctrl_o   = ras_ctrl_reg;
    assign ras_data_o   = ras_data_reg;
    assign multi_br_o   = multi_reg;
    assign inst_valid_o = inst_valid_reg;
    assign br_cnt_o     = cnt_reg;

endmodule

// File: tb/tb_brdec_pipe.sv
// Directed and random bench for brdec_pipe (FETCH_W=8, ADDR_W=64) with a queue scoreboard
// fed by an independent behavioural decode model.
module tb_brdec_pipe;

    typedef struct packed {
        logic        br;
        logic [2:0]  pos;
        logic [1:0]  typ;
        logic [63:0] tar;
        logic [1:0]  ras;
        logic [63:0] rdata;
        logic        multi;
        logic [7:0]  iv;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0, in_valid = 1'b0, ovr = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [63:0]  pc = '0, ras_top = '0;
    logic [255:0] inst = '0;
    logic         in_ready, out_valid, br_exist, btb_we, multi_br;
    logic [2:0]   btb_br_pos;
    logic [1:0]   btb_br_typ, ras_ctrl;
    logic [63:0]  btb_br_tar, ras_data;
    logic [7:0]   inst_valid;
    logic [31:0]  br_cnt;

    // Shadow stimulus, copied onto the DUT inputs just after each rising edge.
    logic         s_rst_n = 1'b0, s_valid = 1'b0, s_ovr = 1'b0, s_flush = 1'b0, s_ready = 1'b0;
    logic [63:0]  s_pc = '0, s_rtop = '0;
    logic [255:0] s_inst = '0;

    res_t        q[$];
    logic [31:0] exp_cnt = '0;
    int          n_total = 0, n_pass = 0;
    logic [5:0]  ops [8] = '{6'h30, 6'h34, 6'h31, 6'h3F, 6'h1A, 6'h10, 6'h00, 6'h2F};

    always #5 clk = ~clk;

    brdec_pipe #(.FETCH_W(8), .ADDR_W(64)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .pc_i(pc), .inst_i(inst), .ras_top_i(ras_top), .valid_override_i(ovr),
        .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .br_exist_o(br_exist), .btb_we_o(btb_we), .btb_br_pos_o(btb_br_pos),
        .btb_br_typ_o(btb_br_typ), .btb_br_tar_o(btb_br_tar), .ras_ctrl_o(ras_ctrl),
        .ras_data_o(ras_data), .multi_br_o(multi_br), .inst_valid_o(inst_valid),
        .br_cnt_o(br_cnt)
    );

    function automatic logic [31:0] f_dir(input logic [5:0] op, input logic [20:0] d);
        return {op, 5'd0, d};
    endfunction

    function automatic logic [31:0] f_ind(input logic [1:0] h);
        return {6'h1A, 10'd0, h, 14'd0};
    endfunction

    function automatic res_t model(input logic [63:0] p, input logic [255:0] ins,
                                   input logic [63:0] rtop, input logic kill);
        res_t r;
        int nb;
        logic [31:0] w;
        logic [5:0] op;
        logic isb;
        logic [1:0] t, ra;
        logic [63:0] spc, dsp;
        r = '0;
        nb = 0;
        if (kill) return r;
        for (int k = int'(p[4:2]); k < 8; k++) begin
            if (nb == 0) r.iv[k] = 1'b1;
            w = ins[32*k +: 32];
            op = w[31:26];
            isb = 1'b1;
            t = 2'd0;
            ra = 2'd0;
            if (op == 6'h30) t = 2'd1;
            else if (op == 6'h34) begin t = 2'd1; ra = 2'd1; end
            else if (op > 6'h30) t = 2'd0;
            else if (op == 6'h1A) begin t = w[15] ? 2'd3 : 2'd2; ra = w[15:14]; end
            else isb = 1'b0;
            if (isb) begin
                if (nb == 0) begin
                    spc = {p[63:5], 5'd0} + 64'(4 * k);
                    dsp = {{41{w[20]}}, w[20:0], 2'b00};
                    r.br = 1'b1;
                    r.pos = 3'(k);
                    r.typ = t;
                    r.ras = ra;
                    r.rdata = spc + 64'd4;
                    r.tar = (t == 2'd3) ? rtop : (t == 2'd2) ? 64'd0 : spc + 64'd4 + dsp;
                end
                nb++;
            end
        end
        r.multi = (nb > 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [255:0] rand_bundle();
        logic [255:0] b;
        logic [31:0] w;
        for (int k = 0; k < 8; k++) begin
            w = $urandom;
            w[31:26] = ops[$urandom_range(0, 7)];
            b[32*k +: 32] = w;
        end
        return b;
    endfunction

    task automatic tick();
        res_t obs, front;
        logic acc;
        @(posedge clk);
        #1;
        rst_n = s_rst_n; in_valid = s_valid; pc = s_pc; inst = s_inst; ras_top = s_rtop;
        ovr = s_ovr; flush = s_flush; out_ready = s_ready;
        @(negedge clk);
        chk("out_valid", out_valid, q.size() != 0);
        chk("br_cnt", br_cnt, exp_cnt);
        chk("in_ready", in_ready, (q.size() == 0) || out_ready);
        if (q.size() != 0) begin
            obs = {br_exist, btb_br_pos, btb_br_typ, btb_br_tar, ras_ctrl, ras_data,
                   multi_br, inst_valid};
            chk("payload", obs, q[0]);
            chk("btb_we", btb_we, q[0].br);
        end
        acc = in_valid && ((q.size() == 0) || out_ready);
        if (q.size() != 0 && out_ready) begin
            front = q.pop_front();
            if (front.br) exp_cnt++;
        end
        if (!rst_n) begin
            q.delete();
            exp_cnt = '0;
        end else if (flush) begin
            q.delete();
        end else if (acc) begin
            q.push_back(model(pc, inst, ras_top, ovr));
        end
    endtask

    initial begin
        logic [31:0] cnt0;
        // Reset
        s_rst_n = 1'b0;
        tick();
        tick();
        chk("rst_payload", {br_exist, btb_br_pos, btb_br_typ, btb_br_tar, ras_ctrl, ras_data,
                            multi_br, inst_valid}, '0);
        chk("rst_cnt", br_cnt, 32'd0);
        s_rst_n = 1'b1;
        tick();

        // BSR in slot 3 from PC 0x1000
        s_valid = 1'b1; s_ready = 1'b1; s_pc = 64'h1000; s_inst = '0;
        s_inst[32*3 +: 32] = f_dir(6'h34, 21'h10);
        tick();
        s_valid = 1'b0; s_ready = 1'b0;
        tick();
        chk("t1_pos", btb_br_pos, 3'd3);
        chk("t1_typ", btb_br_typ, 2'b01);
        chk("t1_tar", btb_br_tar, 64'h1050);
        chk("t1_ras", ras_ctrl, 2'b01);
        chk("t1_rdata", ras_data, 64'h1010);
        chk("t1_iv", inst_valid, 8'h0F);
        s_ready = 1'b1;
        tick();
        tick();
        chk("t1_cnt", br_cnt, 32'd1);

        // RET in slot 6, entry slot 5, earlier BR ignored
        s_valid = 1'b1; s_pc = 64'h1014; s_rtop = 64'hABC0; s_inst = '0;
        s_inst[32*2 +: 32] = f_dir(6'h30, 21'h5);
        s_inst[32*6 +: 32] = f_ind(2'b10);
        tick();
        s_valid = 1'b0;
        tick();
        chk("t2_pos", btb_br_pos, 3'd6);
        chk("t2_typ", btb_br_typ, 2'b11);
        chk("t2_tar", btb_br_tar, 64'hABC0);
        chk("t2_ras", ras_ctrl, 2'b10);
        chk("t2_multi", multi_br, 1'b0);
        chk("t2_iv", inst_valid, 8'h60);

        // Conditional in slot 0 with displacement -1 wraps to 0
        s_valid = 1'b1; s_pc = 64'h0; s_inst = '0;
        s_inst[31:0] = f_dir(6'h31, 21'h1FFFFF);
        tick();
        s_valid = 1'b0;
        tick();
        chk("t3_tar", btb_br_tar, 64'h0);
        chk("t3_typ", btb_br_typ, 2'b00);
        chk("t3_multi", multi_br, 1'b0);
        s_valid = 1'b1;
        s_inst[32*4 +: 32] = f_ind(2'b01);
        tick();
        s_valid = 1'b0;
        tick();
        chk("t3b_multi", multi_br, 1'b1);
        chk("t3b_iv", inst_valid, 8'h01);

        // Backpressure then streaming
        s_valid = 1'b1; s_ready = 1'b1; s_pc = {$urandom, $urandom}; s_inst = rand_bundle();
        tick();
        s_ready = 1'b0; s_inst = rand_bundle(); s_pc = 64'h2000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", in_ready, 1'b0);
        end
        s_ready = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            s_pc = {$urandom, $urandom}; s_rtop = {$urandom, $urandom}; s_inst = rand_bundle();
            tick();
            chk("stream_valid", out_valid, 1'b1);
        end

        // Override kills the bundle
        s_valid = 1'b1; s_ovr = 1'b1; s_pc = 64'h1000; s_inst = '0;
        s_inst[32*1 +: 32] = f_dir(6'h30, 21'h3);
        tick();
        s_valid = 1'b0; s_ovr = 1'b0;
        cnt0 = exp_cnt;
        tick();
        chk("ovr_iv", inst_valid, 8'h00);
        chk("ovr_br", br_exist, 1'b0);
        tick();
        chk("ovr_cnt", br_cnt, cnt0);

        // Flush with same-cycle acceptance
        s_valid = 1'b1; s_flush = 1'b1;
        tick();
        s_valid = 1'b0; s_flush = 1'b0;
        tick();
        chk("flush_valid", out_valid, 1'b0);
        // Flush while the output is stalled
        s_valid = 1'b1; s_ready = 1'b0; s_inst = '0; s_inst[31:0] = f_dir(6'h30, 21'h1);
        tick();
        s_valid = 1'b0; s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        tick();
        chk("flush_hold", out_valid, 1'b0);
        // Flush alongside an output handshake: count still advances
        s_valid = 1'b1; s_ready = 1'b1;
        tick();
        cnt0 = exp_cnt;
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0; s_valid = 1'b0;
        tick();
        chk("flush_cnt", br_cnt, cnt0 + 32'd1);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_ready = ($urandom_range(0, 3) != 0);
            s_flush = ($urandom_range(0, 15) == 0);
            s_ovr   = ($urandom_range(0, 7) == 0);
            s_pc = {$urandom, $urandom}; s_rtop = {$urandom, $urandom}; s_inst = rand_bundle();
            tick();
        end
        s_flush = 1'b0; s_ovr = 1'b0;

        // Mid-stream reset
        s_valid = 1'b1; s_ready = 1'b1; s_inst = '0; s_inst[31:0] = f_dir(6'h30, 21'h2);
        tick();
        tick();
        s_rst_n = 1'b0;
        tick();
        s_rst_n = 1'b1; s_valid = 1'b0;
        tick();
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_cnt", br_cnt, 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
